// File: rtl/eeg_decim_avg.sv
// eeg_decim_avg: block-averaging decimator for signed EEG samples.
//
// Accumulates N = 2^LOG2N accepted samples. The edge that accepts the Nth
// sample writes the rounded and saturated mean to out_data. On that same edge
// the accumulator and counter restart, so consecutive blocks run back to back.
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; clears all state regardless of en
//   en        : clock enable; low holds every register
//   in_valid  : accept in_data on this edge
//   in_data   : W-bit signed sample (most-negative code is clamped)
//   flush     : drop the partial block; a concurrent sample starts the new one
//   out_valid : one-cycle strobe for a new average
//   out_data  : W-bit signed block average, held between strobes
//   fill_cnt  : samples accumulated in the current block (0..N-1)
module eeg_decim_avg #(
  parameter int W     = 24,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             flush,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [LOG2N-1:0] fill_cnt
);

  localparam int AW = W + LOG2N;

  localparam logic signed [W-1:0] S_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN    = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic [W-1:0]        MOST_NEG = {1'b1, {(W-1){1'b0}}};

  // Saturation bounds and rounding offset, sign-extended to the AW+1 rounding width
  localparam logic signed [AW:0] X_MAX = {{(LOG2N+1){1'b0}}, S_MAX};
  localparam logic signed [AW:0] X_MIN = {{(LOG2N+1){1'b1}}, S_MIN};
  localparam logic signed [AW:0] HALF  = (AW+1)'(1) <<< (LOG2N - 1);

  // N-1 is all ones, so the DUMP accept is the one that finds fill_cnt saturated
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  typedef enum logic {ST_ACC, ST_DUMP} phase_t;

  // Clamping the most-negative code keeps the range symmetric, so the
  // average of N clamped samples can never fall outside [S_MIN, S_MAX]
  function automatic logic signed [W-1:0] clamp_in(input logic [W-1:0] x);
    if (x == MOST_NEG) return S_MIN;
    else               return $signed(x);
  endfunction

  // Round half toward +inf: add N/2, then arithmetic shift right by LOG2N
  function automatic logic signed [W-1:0] round_sat(input logic signed [AW-1:0] sum);
    logic signed [AW:0] ext;
    logic signed [AW:0] sh;
    ext = $signed({sum[AW-1], sum}) + HALF;
    sh  = ext >>> LOG2N;
    if (sh > X_MAX)      return S_MAX;
    else if (sh < X_MIN) return S_MIN;
    else                 return sh[W-1:0];
  endfunction

  logic signed [W-1:0]  samp_p0;
  logic signed [AW-1:0] samp_ext_p0;
  logic signed [AW-1:0] sum_p0;
  logic signed [AW-1:0] acc_p0;
  phase_t               phase_p0;

  // Stage p0: clamp, sign-extend and add the incoming sample to the running sum
  assign samp_p0     = clamp_in(in_data);
  assign samp_ext_p0 = {{LOG2N{samp_p0[W-1]}}, samp_p0};
  assign sum_p0      = acc_p0 + samp_ext_p0;
  assign phase_p0    = (fill_cnt == CNT_LAST) ? ST_DUMP : ST_ACC;

  // Stage p1: accumulator, counter and registered average
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0    <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= 1'b0;
      if (flush) begin
        // A sample arriving with flush opens the new block
        acc_p0   <= in_valid ? samp_ext_p0 : '0;
        fill_cnt <= in_valid ? LOG2N'(1) : '0;
      end else if (in_valid) begin
        if (phase_p0 == ST_DUMP) begin
          out_data  <= round_sat(sum_p0);
          out_valid <= 1'b1;
          acc_p0    <= '0;
          fill_cnt  <= '0;
        end else begin
          acc_p0   <= sum_p0;
          fill_cnt <= fill_cnt + LOG2N'(1);
        end
      end
    end
  end

endmodule

// File: doc/eeg_decim_avg.md
EEG_DECIM_AVG -- requirements
Module: eeg_decim_avg

Interface
REQ-001 The block SHALL have parameter W, default 24, meaning sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter LOG2N, default 3, meaning log2 of block length N (N = 8 by default, legal 1..6).
REQ-003 Port clk, input, 1 bit: all state updates on the rising edge only.
REQ-004 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port en, input, 1 bit: clock enable; low means every register holds.
REQ-006 Port in_valid, input, 1 bit: in_data is accepted on this edge.
REQ-007 Port in_data, input, W bits: signed, saturated sample from the upstream saturating adder stage.
REQ-008 Port flush, input, 1 bit: discard the partial block and restart counting.
REQ-009 Port out_valid, output, 1 bit: one-cycle strobe marking a new average.
REQ-010 Port out_data, output, W bits: signed block average, held between strobes.
REQ-011 Port fill_cnt, output, LOG2N bits: samples accumulated in the current block.

Function
REQ-012 A sample SHALL be accepted on a rising edge where en=1, reset=0 and in_valid=1.
REQ-013 An accepted sample equal to the most-negative code (0x800000 at W=24) SHALL be clamped to -(2^(W-1)-1) (0x800001) before accumulation; the accumulation range is symmetric.
REQ-014 The accumulator SHALL be W+LOG2N bits signed, with no wrap for any N in-range samples.
REQ-015 fill_cnt SHALL increment by 1 per accepted sample and wrap 0→N-1→0.
REQ-016 States: ACC (fill_cnt 0..N-2 after accept) and DUMP (the accept that brings the count to N).
REQ-017 On the DUMP edge: out_data SHALL load round(sum of the N samples / N) and out_valid SHALL be 1; the accumulator SHALL load 0 and fill_cnt SHALL load 0.
REQ-018 Rounding SHALL be: add 2^(LOG2N-1) to the full sum, then arithmetic shift right by LOG2N (round half toward +inf), computed in W+LOG2N+1 bits.
REQ-019 The shifted result SHALL saturate to [-(2^(W-1)-1), 2^(W-1)-1], i.e. [0x800001, 0x7FFFFF] at W=24.
REQ-020 Latency SHALL be 1 edge: out_valid is high in the cycle immediately after the edge that accepts the Nth sample.
REQ-021 out_valid SHALL be high for exactly one en=1 cycle; with en=0, out_valid and all other registers SHALL hold.
REQ-022 Each out_valid SHALL be followed by a new block starting with the next accepted sample; back-to-back blocks SHALL need no idle cycles.
REQ-023 flush=1 (with en=1) SHALL clear the accumulator and fill_cnt without producing out_valid; out_data SHALL hold.
REQ-024 On flush and in_valid in the same cycle, flush SHALL win over the partial block, and the concurrent sample SHALL become sample 1 of the new block (fill_cnt=1).
REQ-025 Priority SHALL be: reset > en=0 hold > flush > accept.
REQ-026 in_data SHALL be sampled on the rising edge; the upstream stage launches on the falling edge, which gives half a cycle of setup margin.

Reset
REQ-027 With reset=1 on a rising edge, regardless of en: accumulator=0, fill_cnt=0, out_valid=0, out_data=0.
REQ-028 Reset during a partial block SHALL discard it; no out_valid SHALL result from samples accepted before the reset.

Verification
REQ-029 Check: 8 × 0x000010, in_valid continuous -> out_data=0x000010, out_valid high for 1 cycle after the 8th accept, fill_cnt 1..7 then 0.
REQ-030 Check: 8 × 0x7FFFFF -> 0x7FFFFF; 8 × 0x800000 -> 0x800001 (clamp path).
REQ-031 Check: 4 × 0x000001 then 4 × 0x000000 -> 0x000001 (half rounds up); 8 × 0xFFFFFF -> 0xFFFFFF.
REQ-032 Check: 5 samples, then flush with concurrent 0x000100, then 7 × 0x000100 -> exactly one out_valid, out_data=0x000100.
REQ-033 Check: en=0 for 3 cycles mid-block with in_valid=1 -> fill_cnt and out_data frozen, no sample lost or counted, result identical to the run without the stall.
REQ-034 Check: reset after 6 samples, then 8 × 0x000020 -> out_data=0x000020 with a single strobe; outputs read 0 in the cycle after reset.
